// File: rtl/ysyx_24080006_lsu_axi.sv
// Load/store unit: one request at a time becomes a single-beat AXI4 read or write.
// Define LSU_MISALIGN_TRAP_EN to trap accesses not naturally aligned to their size.
module ysyx_24080006_lsu_axi #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AXI_ID     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_err,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arsize,
    output logic [3:0]              arid,
    output logic [7:0]              arlen,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic [3:0]              awid,
    output logic [7:0]              awlen,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

    state_t                  state, state_d;
    logic                    is_store, is_store_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    req_ready_d, rsp_valid_d, arvalid_d, rready_d;
    logic                    awvalid_d, wvalid_d, bready_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d, wdata_d;
    logic [1:0]              rsp_err_d;
    logic [ADDR_WIDTH-1:0]   araddr_d, awaddr_d;
    logic [2:0]              arsize_d, awsize_d;
    logic [STRB_W-1:0]       wstrb_d;

    logic                    unused_rlast;
    assign unused_rlast = rlast;

    assign arid    = 4'(AXI_ID);
    assign awid    = 4'(AXI_ID);
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    // Request decode: error classification and store lane placement
    logic [1:0]            req_err_c;
    logic [OFF_W-1:0]      off_c;
    logic [2:0]            low_mask_c;
    logic [15:0]           byte_mask_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [STRB_W-1:0]     strb_c;

    always_comb begin
        off_c       = req_addr[OFF_W-1:0];
        low_mask_c  = 3'((4'd1 << req_size) - 4'd1);
        byte_mask_c = (16'd1 << (5'd1 << req_size)) - 16'd1;
        wdata_c     = req_wdata << {off_c, 3'b000};
        strb_c      = STRB_W'(byte_mask_c << off_c);
        req_err_c   = 2'b00;
        if (req_size == 2'd3 && DATA_WIDTH == 32) begin
            req_err_c = 2'b11;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        else if (|(req_addr[2:0] & low_mask_c)) begin
            req_err_c = 2'b01;
        end
`endif
    end

    // Load extraction: shift lane down, then sign/zero-fill above the access width
    logic [DATA_WIDTH-1:0] shifted_c, keep_mask_c, top_bit_c, load_c;
    logic                  sign_c;

    always_comb begin
        shifted_c = rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    keep_mask_c = DATA_WIDTH'(8'hFF);
            2'd1:    keep_mask_c = DATA_WIDTH'(16'hFFFF);
            2'd2:    keep_mask_c = DATA_WIDTH'(32'hFFFF_FFFF);
            default: keep_mask_c = '1;
        endcase
        top_bit_c = keep_mask_c & ~(keep_mask_c >> 1);
        sign_c    = (|(shifted_c & top_bit_c)) & ~uns_q;
        load_c    = (shifted_c & keep_mask_c) | (sign_c ? ~keep_mask_c : '0);
    end

    always_comb begin
        state_d     = state;
        is_store_d  = is_store;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        arvalid_d   = arvalid;
        araddr_d    = araddr;
        arsize_d    = arsize;
        rready_d    = rready;
        awvalid_d   = awvalid;
        awaddr_d    = awaddr;
        awsize_d    = awsize;
        wvalid_d    = wvalid;
        wdata_d     = wdata;
        wstrb_d     = wstrb;
        bready_d    = bready;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    is_store_d  = req_we;
                    off_d       = off_c;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    rsp_rdata_d = '0;
                    rsp_err_d   = req_err_c;
                    if (req_err_c != 2'b00) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (req_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = req_addr;
                        awsize_d  = {1'b0, req_size};
                        wdata_d   = wdata_c;
                        wstrb_d   = strb_c;
                        state_d   = S_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = req_addr;
                        arsize_d  = {1'b0, req_size};
                        state_d   = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (is_store) begin
                    // AW and W retire independently; move on once neither is pending
                    if (awready) awvalid_d = 1'b0;
                    if (wready)  wvalid_d  = 1'b0;
                    if (!(awvalid && !awready) && !(wvalid && !wready)) begin
                        bready_d = 1'b1;
                        state_d  = S_RESP;
                    end
                end else if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (!is_store && rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = rresp[1] ? 2'b10 : 2'b00;
                    rsp_rdata_d = rresp[1] ? '0 : load_c;
                    state_d     = S_DONE;
                end else if (is_store && bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bresp[1] ? 2'b10 : 2'b00;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            is_store  <= 1'b0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arsize    <= '0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awsize    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            bready    <= 1'b0;
        end else begin
            state     <= state_d;
            is_store  <= is_store_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            arvalid   <= arvalid_d;
            araddr    <= araddr_d;
            arsize    <= arsize_d;
            rready    <= rready_d;
            awvalid   <= awvalid_d;
            awaddr    <= awaddr_d;
            awsize    <= awsize_d;
            wvalid    <= wvalid_d;
            wdata     <= wdata_d;
            wstrb     <= wstrb_d;
            bready    <= bready_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_lsu_axi.sv
// Randomized bench for ysyx_24080006_lsu_axi (32-bit bus) with a byte-level reference model
// and a cycle-driven AXI slave with per-channel wait states.
module tb_ysyx_24080006_lsu_axi;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ysyx_24080006_lsu_axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_ID(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arid(arid),
        .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awid(awid),
        .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: bytes addressed within the 4-byte bus word, values via integer arithmetic
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                         input logic [1:0] resp, output logic [1:0] err, output logic [31:0] rdv,
                         output logic [31:0] wdv, output logic [3:0] strb, output bit axi);
        int     off;
        int     nb;
        longint v;
        off  = int'(addr[1:0]);
        nb   = 1 << size;
        err  = 2'd0;
        rdv  = 32'd0;
        wdv  = 32'd0;
        strb = 4'd0;
        axi  = 1'b0;
        if (size == 2'd3) begin
            err = 2'd3;
            return;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (int'(addr[2:0]) % nb != 0) begin
            err = 2'd1;
            return;
        end
`endif
        axi = 1'b1;
        if (resp[1]) err = 2'd2;
        if (we) begin
            v   = longint'(wd) * (longint'(1) << (8 * off));
            wdv = 32'(v);
            for (int b = 0; b < 4; b++) strb[b] = (b >= off) && (b < off + nb);
        end else if (!resp[1]) begin
            v = longint'(rd) / (longint'(1) << (8 * off));
            if (nb < 4) begin
                v = v % (longint'(1) << (8 * nb));
                if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
            end
            rdv = 32'(v);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [1:0] resp, input int ar_w, input int aw_w, input int w_w,
                           input int r_w, input int b_w, input int rsp_w, output int lat);
        logic [1:0]  e_err;
        logic [31:0] e_rd, e_wd;
        logic [3:0]  e_strb;
        bit          axi;
        bit          done;
        int ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
        int ar_c = 0, aw_c = 0, w_c = 0, r_c = 0, b_c = 0, rsp_c = 0;
        model(we, addr, size, uns, wd, rd, resp, e_err, e_rd, e_wd, e_strb, axi);
        lat  = -1;
        done = 1'b0;
        @(negedge clock);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clock);
            if (k == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
                req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
            end
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rsp_ready = 0;
            rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
            if (ar_hs > 0 && r_hs == 0) begin
                if (r_c >= r_w) begin
                    rvalid = 1; rdata = rd; rresp = resp;
                    if (rready) r_hs++;
                end else r_c++;
            end
            if (aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
                if (b_c >= b_w) begin
                    bvalid = 1; bresp = resp;
                    if (bready) b_hs++;
                end else b_c++;
            end
            if (arvalid) begin
                if (ar_c >= ar_w) begin
                    arready = 1; ar_hs++;
                    check("araddr", araddr, addr);
                    check("arsize", arsize, {1'b0, size});
                    check("ar_id_len_burst", {arid, arlen, arburst}, {4'd1, 8'd0, 2'b01});
                end else ar_c++;
            end
            if (awvalid) begin
                if (aw_c >= aw_w) begin
                    awready = 1; aw_hs++;
                    check("awaddr", awaddr, addr);
                    check("awsize", awsize, {1'b0, size});
                    check("aw_id_len_burst", {awid, awlen, awburst}, {4'd1, 8'd0, 2'b01});
                end else aw_c++;
            end
            if (wvalid) begin
                if (w_c >= w_w) begin
                    wready = 1; w_hs++;
                    check("wdata", wdata, e_wd);
                    check("wstrb", wstrb, e_strb);
                    check("wlast", wlast, 1);
                end else w_c++;
            end
            if (rsp_valid) begin
                if (lat < 0) lat = k;
                check("rsp_rdata", rsp_rdata, e_rd);
                check("rsp_err", rsp_err, e_err);
                check("req_ready_busy", req_ready, 0);
                if (rsp_c >= rsp_w) begin
                    rsp_ready = 1; done = 1'b1;
                end else rsp_c++;
            end
        end
        if (!done) check("rsp_timeout", 0, 1);
        @(negedge clock);
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rsp_ready = 0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
        check("ar_count", ar_hs, (axi && !we) ? 1 : 0);
        check("r_count", r_hs, (axi && !we) ? 1 : 0);
        check("aw_count", aw_hs, (axi && we) ? 1 : 0);
        check("w_count", w_hs, (axi && we) ? 1 : 0);
        check("b_count", b_hs, (axi && we) ? 1 : 0);
    endtask

    initial begin
        int lat;
        logic [1:0] resp_tab [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_unsigned = 0;
        req_wdata = 0; rsp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("rst_axi_ctl", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_axi_data", {araddr, awaddr}, 0);
        check("rst_axi_wd", {wdata, wstrb, arsize, awsize}, 0);
        @(negedge clock); @(negedge clock);
        reset = 0;

        run_txn(0, 32'h8000_0003, 2'd0, 0, 32'h0, 32'h8000_0000, 2'd0, 0, 0, 0, 0, 0, 0, lat);
        check("load_latency", lat, 3);
        run_txn(0, 32'h8000_0003, 2'd0, 1, 32'h0, 32'h8000_0000, 2'd0, 1, 0, 0, 2, 0, 0, lat);
        run_txn(1, 32'h8000_0002, 2'd1, 0, 32'h1234, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, lat);
        check("store_latency", lat, 3);
        run_txn(1, 32'h8000_0000, 2'd2, 0, 32'hDEAD_BEEF, 32'h0, 2'd0, 0, 3, 0, 0, 1, 0, lat);
        run_txn(1, 32'h8000_0001, 2'd0, 0, 32'h0000_00A5, 32'h0, 2'd2, 2, 0, 4, 0, 2, 1, lat);
        run_txn(0, 32'h8000_0004, 2'd2, 0, 32'h0, 32'h1357_9BDF, 2'd2, 0, 0, 0, 1, 0, 5, lat);
        run_txn(0, 32'h8000_0002, 2'd2, 0, 32'h0, 32'hCAFE_8001, 2'd0, 0, 0, 0, 0, 0, 0, lat);
        run_txn(0, 32'h8000_0000, 2'd3, 0, 32'h0, 32'h1111_1111, 2'd0, 0, 0, 0, 0, 0, 2, lat);
        check("err_latency", lat, 1);
        run_txn(1, 32'h8000_0008, 2'd3, 0, 32'h55AA, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, lat);

        // Reset while a read address is outstanding: AR drops at once, no response follows
        @(negedge clock);
        req_valid = 1; req_we = 0; req_addr = 32'h8000_0010; req_size = 2'd2;
        @(negedge clock);
        req_valid = 0;
        check("arvalid_before_rst", arvalid, 1);
        #2 reset = 1;
        #1;
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            arready = 1; rvalid = 1; rdata = $urandom;
            @(negedge clock);
            check("post_rst_quiet", {rsp_valid, arvalid, rready}, 0);
        end
        arready = 0; rvalid = 0;

        for (int i = 0; i < 200; i++) begin
            logic [1:0] sz;
            sz = 2'($urandom_range(0, 3));
            run_txn(1'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 63)), sz,
                    1'($urandom), $urandom, $urandom, resp_tab[$urandom_range(0, 5)],
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
